// File: rtl/jdrosent_debounce.sv
// Six-channel two-flop synchronizer and counter-based debouncer.
// Outputs the debounced levels, a one-cycle change strobe and a busy flag.
module jdrosent_debounce #(
  parameter int STABLE_CYCLES = 8
) (
  input  logic [7:0] io_i,
  output logic [7:0] io_o
);

  localparam logic [3:0] LAST_COUNT = 4'(STABLE_CYCLES - 1);

  logic       clk;
  logic       rst;
  logic [5:0] raw;

  assign clk = io_i[0];
  assign rst = io_i[1];
  assign raw = io_i[7:2];

  logic [5:0]      s1_q, s1_d;
  logic [5:0]      s2_q, s2_d;
  logic [5:0]      db_q, db_d;
  logic [5:0][3:0] cnt_q, cnt_d;
  logic            chg_q, chg_d;
  logic [5:0]      flip;

  // A differing level restarts from zero whenever s2 falls back to db.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = cnt_q;
    flip  = '0;
    for (int c = 0; c < 6; c++) begin
      if (s2_q[c] == db_q[c]) begin
        cnt_d[c] = 4'd0;
      end else if (cnt_q[c] == LAST_COUNT) begin
        db_d[c]  = s2_q[c];
        cnt_d[c] = 4'd0;
        flip[c]  = 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c] + 4'd1;
      end
    end
    chg_d = |flip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      cnt_q <= '0;
      chg_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      db_q  <= db_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end

  assign io_o = {|(s2_q ^ db_q), chg_q, db_q};

endmodule

// File: doc/jdrosent_debounce.md
# jdrosent_debounce

Six-channel input synchronizer and debouncer for raw switch/button inputs on a Tiny Tapeout tile. It sits directly upstream of the rising-edge detector. It converts asynchronous, bouncing pad inputs into clean, clock-synchronous levels that the detector can sample without glitch pulses. It also emits a one-cycle "any level changed" strobe and a busy flag for bring-up observation.

## Interface
- STABLE_CYCLES, default 8: consecutive synchronized cycles an input must differ from its debounced level before the level flips. Legal range 2..16.
- Counter width is fixed at 4 bits per channel.
- io_i[0]  input  1  clock. One clock domain; all state is on its rising edge.
- io_i[1]  input  1  reset. Asynchronous, active-high.
- io_i[7:2]  input  6  raw asynchronous inputs, channel c = io_i[c+2].
- io_o[5:0]  output  6  debounced level of channel c on io_o[c].
- io_o[6]  output  1  change strobe. High for one cycle when any debounced level flips.
- io_o[7]  output  1  busy. High while any channel's synchronized input differs from its debounced level.

## Operation
- Per-channel state:
  - two-flop synchronizer, s1 then s2;
  - 4-bit counter cnt;
  - debounced level db.
- Shared state: a registered strobe chg.
- Reset: every s1, s2, cnt, db and chg clears to 0 asynchronously. io_o is 0x00 immediately, not at the next edge.
- Each clock edge, per channel:
  - s1 <= raw input; s2 <= s1.
  - If s2 == db: cnt <= 0. This is a restart of the count, not a decrement.
  - Else if cnt == STABLE_CYCLES-1: db <= s2 and cnt <= 0; the channel flags a flip.
  - Else: cnt <= cnt+1.
- chg <= OR of all channel flips this edge. Simultaneous flips on several channels give a single strobe.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around. For STABLE_CYCLES=16 the maximum count is 15, which fits in 4 bits.
- busy is combinational: OR over channels of (s2 != db). It is driven from registers only; there is no direct path from the pads.
- Channels are fully independent, apart from the shared chg and busy ORs.
- Downstream: io_o[5:0] feeds the rising-edge detector directly. io_o[6] is informational only.

## Timing
- Numbering: edge E0 is the first rising edge that samples a new raw value into s1.
  - s2 shows the new value after edge E0+1.
  - db and io_o[c] update at edge E0+STABLE_CYCLES+1.
  - For the default (8), the output changes at E0+9, i.e. the 10th sampling edge.
- io_o[6] rises at the same edge as the db flip and falls at the next edge. Its width is exactly one cycle.
- io_o[7] rises at edge E0+1 and falls at the edge where db flips.
- Glitches: if s2 returns to db before the count completes, cnt clears and db never changes. Neither io_o[c] nor io_o[6] toggles. io_o[7] pulses for the glitch duration, as seen at s2.
- Bounce: each return of s2 to db restarts the count. The output flips STABLE_CYCLES+1 edges after the final raw transition, provided that transition is sampled at E0.
- Reset mid-count discards all partial counts. After release, a steadily held input needs the full STABLE_CYCLES+2 edges again.
- Raw inputs need no setup/hold relative to the clock; metastability is confined to s1.

## Test plan
- **Reset idle:** assert io_i[1], all raw inputs 0, then release for 20 cycles.
  - Required: io_o = 0x00 throughout.
- **Clean rise (default N=8):** after reset, set io_i[2]=1 before edge E0 and hold.
  - Required: io_o[0]=1 from edge E0+9.
  - Required: io_o[6]=1 for exactly that one cycle.
  - Required: io_o[7]=1 from E0+1 through E0+8, then 0.
- **Glitch rejection:** pulse io_i[3] high for 5 cycles, then low.
  - Required: io_o[1] stays 0 and io_o[6] never asserts.
  - Required: io_o[7] is high for 5 cycles.
- **Bounce then settle:** toggle io_i[4] every 3 cycles for 21 cycles, then hold high (final rise sampled at E0).
  - Required: io_o[2] stays 0 until edge E0+9, then 1.
  - Required: exactly one io_o[6] pulse.
- **All channels together:** set io_i[7:2]=6'b111111 in one cycle.
  - Required: io_o[5:0] goes 0x00 to 0x3F in a single cycle, with one io_o[6] pulse.
  - Then clear all inputs: the same behaviour back to 0x00.
- **Reset mid-count:** hold io_i[5]=1, then assert reset after edge E0+5.
  - Required: io_o clears asynchronously while reset is high.
  - Required: after release, io_o[3] rises at the 10th edge counted from the first post-release sampling edge.
